// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the 1:8 demux sequencing controller.
package demux_ctrl_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // One-hot channel mask for a select value.
    function automatic logic [NCH-1:0] onehot8(input logic [SEL_W-1:0] sel);
        onehot8 = NCH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux1_8_ctrl_chan_timer.sv
// Per-channel hold-off timer: counts cycles a channel has been offered a
// word without accepting it and flags the last allowed cycle.
module chan_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Clear has priority so a new channel always starts counting from zero.
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire = (timer_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/demux1_8_ctrl.sv
// Sequencing controller for the 1:8 demux. Accepts a tagged word, then
// offers it to one channel (unicast) or to channels 0..7 in turn (scan).
// A channel that does not accept within TIMEOUT cycles is skipped and the
// drop is counted. sel and out_data feed the external demux instance
// (sel[2]->S1, sel[1]->S2, sel[0]->S3, out_data->I).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn before that edge except by a timeout
// drop or reset, and in_ready/out_valid depend only on registered state.
module demux1_8_ctrl
    import demux_ctrl_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [2:0]    in_dest,
    input  logic          scan_en,
    output logic [2:0]    sel,
    output logic [DW-1:0] out_data,
    output logic [7:0]    out_valid,
    input  logic [7:0]    out_ready,
    output logic          busy,
    output logic          timeout_pulse,
    output logic [7:0]    drop_cnt
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DW-1:0]     data_q, data_d;
    logic              scan_q, scan_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expire;
    logic ch_ready;

    chan_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_chan_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    assign ch_ready = out_ready[sel_q];

    // Next-state, datapath capture and drop accounting.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        data_d        = data_q;
        scan_d        = scan_q;
        drop_cnt_d    = drop_cnt_q;
        timer_clear   = 1'b0;
        timer_en      = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    scan_d  = scan_en;
                    sel_d   = scan_en ? '0 : in_dest;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ch_ready || timer_expire) begin
                    // Delivery beats an expiring timer in the same cycle.
                    if (!ch_ready) begin
                        timeout_pulse = 1'b1;
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                    end
                    timer_clear = 1'b1;
                    if (scan_q && (sel_q != SEL_W'(NCH - 1))) begin
                        sel_d = sel_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset discards any word in flight uncounted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            data_q     <= '0;
            scan_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            scan_q     <= scan_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SEND);
    assign out_valid = (state_q == SEND) ? onehot8(sel_q) : 8'h00;
    assign sel       = sel_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
